ethercat_fmmu_multi: RTL and testbench
======================================

# ethercat_fmmu_multi

Parametrised, multi-channel successor to the single-FMMU mapper. It sits between the EtherCAT datagram byte stream and the slave's local process-data bus. For logical datagrams (LRD/LWR/LRW), it translates each byte's logical address through up to N_FMMU configured channels, performs per-byte local reads and writes, and substitutes read data into the outgoing stream. At datagram end it reports the working-counter increment.

## Interface
- N_FMMU, 4: number of FMMU channels (1..8); lower index has higher priority.
- AW, 16: physical/local bus address width.
- rxc in 1: clock; all logic on rising edge.
- rst in 1: reset, synchronous, active-high.
- dg_start in 1: one-cycle pulse; latches dg_cmd/dg_addr/dg_len.
- dg_cmd in 8: datagram command; 0x0A LRD, 0x0B LWR, 0x0C LRW, others pass through.
- dg_addr in 32: logical start address.
- dg_len in 16: datagram data length in bytes.
- byte_valid in 1: byte_in valid; accepted when byte_valid & byte_ready.
- byte_in in 8: incoming frame data byte.
- byte_ready out 1: block can accept a byte.
- byte_out out 8: outgoing frame byte.
- byte_out_valid out 1: one-cycle strobe per byte_out.
- dg_done out 1: one-cycle pulse after the last byte_out.
- wkc_inc out 2: valid with dg_done; read_hit + 2*write_hit.
- cfg_enable in N_FMMU: per-channel enable.
- cfg_rd_en, cfg_wr_en in N_FMMU: per-channel read and write type.
- cfg_log_start in 32*N_FMMU: logical start per channel, channel i at [32i+:32].
- cfg_log_len in 16*N_FMMU: logical length in bytes per channel.
- cfg_phy_start in AW*N_FMMU: physical start per channel.
- bus_address out AW: local bus address.
- bus_rd, bus_wr out 1: request strobes, held until bus_ack.
- bus_wdata out 8: write data.
- bus_rdata in 8: read data, sampled on bus_ack.
- bus_ack in 1: completes the current request.

## Operation
- States:
  - IDLE: waits for dg_start.
  - WAIT_BYTE: byte_ready=1.
  - RD_REQ, WR_REQ: local bus transfer for the current byte.
  - EMIT: drives the byte to the stream.
  - DONE: end-of-datagram handling.
- dg_start in any state aborts the current datagram and latches new fields. There is no dg_done for the aborted datagram. A bus request in flight is dropped the same cycle.
- On latch, offset is cleared, hit flags are cleared, and the state goes to WAIT_BYTE. If dg_len=0, the state goes to DONE.
- Logical address for a byte: la = dg_addr + offset, modulo 2^32.
- Channel i hits when all of the following hold:
  - cfg_enable[i] is set.
  - (la - log_start_i) mod 2^32 < log_len_i. This handles 32-bit wrap; log_len=0 never hits.
  - Type matches: rd needs cfg_rd_en and LRD/LRW; wr needs cfg_wr_en and LWR/LRW.
- The lowest hitting index wins. The physical address is phy_start + (la - log_start), truncated to AW.
- Per accepted byte:
  - No hit or non-logical command: goes to EMIT with byte_out=byte_in.
  - Read hit: goes to RD_REQ; byte_out=bus_rdata.
  - Write hit: goes to WR_REQ with bus_wdata=byte_in; byte_out=byte_in for LWR.
  - LRW with both types on the winning channel: RD_REQ, then WR_REQ (same address), then EMIT with the read data.
- read_hit and write_hit are sticky per datagram; each is set on the first bus_ack of that type.
- EMIT: increments offset. If offset==dg_len the state goes to DONE, else WAIT_BYTE.
- DONE: pulses dg_done with wkc_inc, then returns to IDLE.
- Config inputs are sampled per byte. The team guarantees they are static during a datagram.

## Timing
- Reset values: state IDLE; byte_ready 0; byte_out 0x00; byte_out_valid 0; dg_done 0; wkc_inc 0; bus_rd 0; bus_wr 0; bus_address 0; bus_wdata 0.
- Reset takes precedence over dg_start. A mid-datagram reset drops strobes on the next edge with no dg_done.
- byte_ready=0 from the acceptance cycle until return to WAIT_BYTE.
- Pass-through byte: byte_out_valid 1 cycle after acceptance.
- Read byte: bus_rd rises 1 cycle after acceptance and holds through the bus_ack cycle. byte_out_valid follows 1 cycle after bus_ack. An ack in the same cycle as the request gives 2-cycle latency.
- Write byte: bus_wr is handled likewise. bus_address and bus_wdata are stable while a strobe is high.
- bus_rd and bus_wr are never high together. bus_ack while idle is ignored.
- dg_done comes 1 cycle after the last byte_out_valid. With dg_len=0, it comes 2 cycles after dg_start.

## Structure
- ethercat_fmmu_pkg holds:
  - Command constants CMD_LRD/LWR/LRW.
  - The state enum.
  - The fmmu_cfg_t struct (enable, rd_en, wr_en, log_start, log_len, phy_start).
  - Function wkc_calc.
- Sub-module fmmu_match: combinational per-channel range and type compare, priority encoder, and physical address output. It is instantiated once with N_FMMU channels.

## Test plan
- Channel 0: log 0x14141413, len 4, phy 0x3333, rd. LRD at 0x14141414, len 2. Expect bus_rd at 0x3334 and 0x3335; byte_out = rdata 0xA1, 0xA2; wkc_inc=1.
- Same channel set to wr. LWR at 0x14141412, len 3, bytes 0x11 0x22 0x33. Expect 0x11 passes through with no bus op; writes 0x22→0x3333 and 0x33→0x3334; wkc_inc=2.
- Channels 0 and 1 overlap at 0x1000 (phy 0x0100 and 0x0800). LRW at 0x1000 with channel 0 rd+wr. Expect bus_rd then bus_wr at 0x0100 only; wkc_inc=3.
- Wrap case: channel 2 log 0xFFFFFFFE, len 4, phy 0x0200, rd. LRD at 0xFFFFFFFF, len 2. Expect addresses 0x0201 and 0x0202.
- Stall case: bus_ack held low for 5 cycles. Expect bus_rd held and byte_ready low; assert rst mid-datagram. Expect all outputs at reset values next cycle and no dg_done.
- Command 0x00, len 2, and separately dg_len=0. Expect bytes pass through unchanged with no bus activity and wkc_inc=0; dg_done 2 cycles after dg_start when len=0.

Source files
------------

// File: rtl/ethercat_fmmu_multi_pkg.sv
// Shared types and constants for the multi-channel EtherCAT FMMU mapper.
// Command codes, FSM states, per-channel configuration record, WKC helper.
package ethercat_fmmu_pkg;

  localparam logic [7:0] CMD_LRD = 8'h0A;
  localparam logic [7:0] CMD_LWR = 8'h0B;
  localparam logic [7:0] CMD_LRW = 8'h0C;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_BYTE,
    ST_RD_REQ,
    ST_WR_REQ,
    ST_EMIT,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic        enable;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] log_start;
    logic [15:0] log_len;
    logic [31:0] phy_start;
  } fmmu_cfg_t;

  function automatic logic [1:0] wkc_calc(input logic read_hit, input logic write_hit);
    return {write_hit, read_hit};
  endfunction

endpackage

// File: rtl/ethercat_fmmu_multi_if.sv
// Local process-data bus between the FMMU mapper (master) and slave memory.
interface ethercat_fmmu_multi_if #(
  parameter int AW = 16
) ();
  logic [AW-1:0] bus_address;
  logic          bus_rd;
  logic          bus_wr;
  logic [7:0]    bus_wdata;
  logic [7:0]    bus_rdata;
  logic          bus_ack;

  modport master (
    output bus_address, bus_rd, bus_wr, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_address, bus_rd, bus_wr, bus_wdata,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/ethercat_fmmu_multi_match.sv
// Combinational FMMU channel lookup: wrap-safe range check, type match,
// lowest-index priority and physical address translation.
module fmmu_match
  import ethercat_fmmu_pkg::*;
#(
  parameter int N_FMMU = 4,
  parameter int AW     = 16
) (
  input  logic [31:0]   la,
  input  logic          is_rd,
  input  logic          is_wr,
  input  fmmu_cfg_t     cfg [N_FMMU],
  output logic          hit,
  output logic          do_rd,
  output logic          do_wr,
  output logic [AW-1:0] phy_addr
);

  logic [31:0] diff;

  always_comb begin
    hit      = 1'b0;
    do_rd    = 1'b0;
    do_wr    = 1'b0;
    phy_addr = '0;
    diff     = '0;
    for (int unsigned i = 0; i < N_FMMU; i++) begin
      // Modular offset makes ranges that straddle 2^32 work without special casing
      diff = la - cfg[i].log_start;
      if (!hit && cfg[i].enable && (diff < {16'h0000, cfg[i].log_len}) &&
          ((cfg[i].rd_en && is_rd) || (cfg[i].wr_en && is_wr))) begin
        hit      = 1'b1;
        do_rd    = cfg[i].rd_en && is_rd;
        do_wr    = cfg[i].wr_en && is_wr;
        phy_addr = AW'(cfg[i].phy_start + diff);
      end
    end
  end

endmodule

// File: rtl/ethercat_fmmu_multi.sv
// Multi-channel FMMU: maps logical datagram bytes onto the local bus,
// substitutes read data into the stream and reports the WKC increment.
module ethercat_fmmu_multi
  import ethercat_fmmu_pkg::*;
#(
  parameter int N_FMMU = 4,
  parameter int AW     = 16
) (
  input  logic                 rxc,
  input  logic                 rst,
  input  logic                 dg_start,
  input  logic [7:0]           dg_cmd,
  input  logic [31:0]          dg_addr,
  input  logic [15:0]          dg_len,
  input  logic                 byte_valid,
  input  logic [7:0]           byte_in,
  output logic                 byte_ready,
  output logic [7:0]           byte_out,
  output logic                 byte_out_valid,
  output logic                 dg_done,
  output logic [1:0]           wkc_inc,
  input  logic [N_FMMU-1:0]    cfg_enable,
  input  logic [N_FMMU-1:0]    cfg_rd_en,
  input  logic [N_FMMU-1:0]    cfg_wr_en,
  input  logic [32*N_FMMU-1:0] cfg_log_start,
  input  logic [16*N_FMMU-1:0] cfg_log_len,
  input  logic [AW*N_FMMU-1:0] cfg_phy_start,
  ethercat_fmmu_multi_if.master bus
);

  state_t        state, state_n;
  logic [7:0]    cmd_q;
  logic [31:0]   base_q;
  logic [15:0]   len_q, offset_q;
  logic          rd_hit_q, wr_hit_q, do_wr_q;
  logic [7:0]    out_q, wdata_q;
  logic [AW-1:0] addr_q;
  logic          rd_strobe, wr_strobe;

  fmmu_cfg_t     cfg [N_FMMU];
  logic [31:0]   la;
  logic          is_rd_cmd, is_wr_cmd;
  logic          m_hit, m_rd, m_wr;
  logic [AW-1:0] m_phy;

  always_comb begin
    for (int unsigned i = 0; i < N_FMMU; i++) begin
      cfg[i]                     = '0;
      cfg[i].enable              = cfg_enable[i];
      cfg[i].rd_en               = cfg_rd_en[i];
      cfg[i].wr_en               = cfg_wr_en[i];
      cfg[i].log_start           = cfg_log_start[32*i +: 32];
      cfg[i].log_len             = cfg_log_len[16*i +: 16];
      cfg[i].phy_start[AW-1:0]   = cfg_phy_start[AW*i +: AW];
    end
  end

  assign la        = base_q + {16'h0000, offset_q};
  assign is_rd_cmd = (cmd_q == CMD_LRD) || (cmd_q == CMD_LRW);
  assign is_wr_cmd = (cmd_q == CMD_LWR) || (cmd_q == CMD_LRW);

  fmmu_match #(.N_FMMU(N_FMMU), .AW(AW)) u_match (
    .la       (la),
    .is_rd    (is_rd_cmd),
    .is_wr    (is_wr_cmd),
    .cfg      (cfg),
    .hit      (m_hit),
    .do_rd    (m_rd),
    .do_wr    (m_wr),
    .phy_addr (m_phy)
  );

  // dg_start squashes strobes and handshakes in the same cycle it is seen.
  // A zero-length datagram still passes through WAIT_BYTE (byte_ready low),
  // which places dg_done two cycles after dg_start.
  always_comb begin
    state_n        = state;
    byte_ready     = 1'b0;
    byte_out_valid = 1'b0;
    dg_done        = 1'b0;
    wkc_inc        = '0;
    rd_strobe      = 1'b0;
    wr_strobe      = 1'b0;
    if (dg_start) begin
      state_n = ST_WAIT_BYTE;
    end else begin
      case (state)
        ST_IDLE: ;
        ST_WAIT_BYTE: begin
          if (len_q == '0) begin
            state_n = ST_DONE;
          end else begin
            byte_ready = 1'b1;
            if (byte_valid)
              state_n = m_rd ? ST_RD_REQ : (m_wr ? ST_WR_REQ : ST_EMIT);
          end
        end
        ST_RD_REQ: begin
          rd_strobe = 1'b1;
          if (bus.bus_ack) state_n = do_wr_q ? ST_WR_REQ : ST_EMIT;
        end
        ST_WR_REQ: begin
          wr_strobe = 1'b1;
          if (bus.bus_ack) state_n = ST_EMIT;
        end
        ST_EMIT: begin
          byte_out_valid = 1'b1;
          state_n = (offset_q + 16'd1 == len_q) ? ST_DONE : ST_WAIT_BYTE;
        end
        ST_DONE: begin
          dg_done = 1'b1;
          wkc_inc = wkc_calc(rd_hit_q, wr_hit_q);
          state_n = ST_IDLE;
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge rxc) begin
    if (rst) begin
      state    <= ST_IDLE;
      cmd_q    <= '0;
      base_q   <= '0;
      len_q    <= '0;
      offset_q <= '0;
      rd_hit_q <= 1'b0;
      wr_hit_q <= 1'b0;
      do_wr_q  <= 1'b0;
      out_q    <= '0;
      wdata_q  <= '0;
      addr_q   <= '0;
    end else begin
      state <= state_n;
      if (dg_start) begin
        cmd_q    <= dg_cmd;
        base_q   <= dg_addr;
        len_q    <= dg_len;
        offset_q <= '0;
        rd_hit_q <= 1'b0;
        wr_hit_q <= 1'b0;
      end else begin
        case (state)
          ST_WAIT_BYTE: begin
            if (byte_ready && byte_valid) begin
              out_q   <= byte_in;
              do_wr_q <= m_wr;
              if (m_hit) begin
                addr_q  <= m_phy;
                wdata_q <= byte_in;
              end
            end
          end
          ST_RD_REQ: begin
            if (bus.bus_ack) begin
              out_q    <= bus.bus_rdata;
              rd_hit_q <= 1'b1;
            end
          end
          ST_WR_REQ: if (bus.bus_ack) wr_hit_q <= 1'b1;
          ST_EMIT:   offset_q <= offset_q + 16'd1;
          default: ;
        endcase
      end
    end
  end

  assign byte_out        = out_q;
  assign bus.bus_address = addr_q;
  assign bus.bus_wdata   = wdata_q;
  assign bus.bus_rd      = rd_strobe;
  assign bus.bus_wr      = wr_strobe;

endmodule

// File: tb/tb_ethercat_fmmu_multi.sv
// Scoreboard bench for ethercat_fmmu_multi: expected bytes, bus ops and WKC
// are queued up front and matched against what the DUT produces.
module tb_ethercat_fmmu_multi;
  import ethercat_fmmu_pkg::*;

  localparam int N  = 4;
  localparam int AW = 16;

  logic              rxc = 1'b0;
  logic              rst = 1'b1;
  logic              dg_start = 1'b0;
  logic [7:0]        dg_cmd = '0;
  logic [31:0]       dg_addr = '0;
  logic [15:0]       dg_len = '0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_in = '0;
  logic              byte_ready;
  logic [7:0]        byte_out;
  logic              byte_out_valid;
  logic              dg_done;
  logic [1:0]        wkc_inc;
  logic [N-1:0]      cfg_enable, cfg_rd_en, cfg_wr_en;
  logic [32*N-1:0]   cfg_log_start;
  logic [16*N-1:0]   cfg_log_len;
  logic [AW*N-1:0]   cfg_phy_start;

  always #5 rxc = ~rxc;

  ethercat_fmmu_multi_if #(.AW(AW)) bus_if ();

  ethercat_fmmu_multi #(.N_FMMU(N), .AW(AW)) dut (
    .rxc            (rxc),
    .rst            (rst),
    .dg_start       (dg_start),
    .dg_cmd         (dg_cmd),
    .dg_addr        (dg_addr),
    .dg_len         (dg_len),
    .byte_valid     (byte_valid),
    .byte_in        (byte_in),
    .byte_ready     (byte_ready),
    .byte_out       (byte_out),
    .byte_out_valid (byte_out_valid),
    .dg_done        (dg_done),
    .wkc_inc        (wkc_inc),
    .cfg_enable     (cfg_enable),
    .cfg_rd_en      (cfg_rd_en),
    .cfg_wr_en      (cfg_wr_en),
    .cfg_log_start  (cfg_log_start),
    .cfg_log_len    (cfg_log_len),
    .cfg_phy_start  (cfg_phy_start),
    .bus            (bus_if)
  );

  // miss=1 marks "no operation observed"
  typedef struct packed {
    logic        miss;
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  data;
  } op_t;

  logic [7:0] stim_bytes [$];
  logic [7:0] exp_out [$];
  logic [7:0] obs_out [$];
  op_t        exp_ops [$];
  op_t        obs_ops [$];
  logic [1:0] exp_wkc [$];
  logic [1:0] obs_wkc [$];
  logic [7:0] mem [0:65535];

  int tests = 0;
  int fails = 0;
  int first_acc, first_strobe, first_valid, last_valid, done_cyc, both_cnt;
  bit done_seen;

  task automatic clear_cfg();
    cfg_enable = '0; cfg_rd_en = '0; cfg_wr_en = '0;
    cfg_log_start = '0; cfg_log_len = '0; cfg_phy_start = '0;
  endtask

  task automatic set_ch(input int unsigned ch, input logic rd, input logic wr,
                        input logic [31:0] ls, input logic [15:0] ll, input logic [15:0] ps);
    cfg_enable[ch] = 1'b1;
    cfg_rd_en[ch]  = rd;
    cfg_wr_en[ch]  = wr;
    cfg_log_start[32*ch +: 32] = ls;
    cfg_log_len[16*ch +: 16]   = ll;
    cfg_phy_start[AW*ch +: AW] = ps;
  endtask

  // Drives one datagram, answers the local bus from mem, records what comes out.
  task automatic run_dg(input logic [7:0] cmd, input logic [31:0] addr,
                        input logic [15:0] len, input int unsigned ack_delay);
    int unsigned bi, stall;
    logic rdy;
    obs_out.delete(); obs_ops.delete(); obs_wkc.delete();
    first_acc = -1; first_strobe = -1; first_valid = -1; last_valid = -1;
    done_cyc = -1; both_cnt = 0; done_seen = 0;
    bi = 0; stall = 0;
    @(negedge rxc);
    dg_cmd = cmd; dg_addr = addr; dg_len = len; dg_start = 1'b1;
    for (int cyc = 1; cyc <= 300 && !done_seen; cyc++) begin
      @(negedge rxc);
      rdy = byte_ready;
      if (bus_if.bus_rd && bus_if.bus_wr) both_cnt++;
      if (byte_out_valid) begin
        obs_out.push_back(byte_out);
        if (first_valid < 0) first_valid = cyc;
        last_valid = cyc;
      end
      if (dg_done) begin
        obs_wkc.push_back(wkc_inc);
        done_cyc = cyc;
        done_seen = 1;
      end
      dg_start = 1'b0;
      byte_valid = 1'b0;
      bus_if.bus_ack = 1'b0;
      if (bus_if.bus_rd || bus_if.bus_wr) begin
        if (first_strobe < 0) first_strobe = cyc;
        if (stall >= ack_delay) begin
          stall = 0;
          bus_if.bus_ack = 1'b1;
          if (bus_if.bus_rd) begin
            bus_if.bus_rdata = mem[bus_if.bus_address];
            obs_ops.push_back('{1'b0, 1'b0, bus_if.bus_address, 8'h00});
          end else begin
            mem[bus_if.bus_address] = bus_if.bus_wdata;
            obs_ops.push_back('{1'b0, 1'b1, bus_if.bus_address, bus_if.bus_wdata});
          end
        end else begin
          stall++;
        end
      end
      if (rdy && bi < len) begin
        byte_valid = 1'b1;
        byte_in = stim_bytes[bi];
        if (first_acc < 0) first_acc = cyc;
        bi++;
      end
    end
    @(negedge rxc);
    bus_if.bus_ack = 1'b0;
    byte_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge rxc);
    tests++;
    if ({byte_ready, byte_out, byte_out_valid, dg_done, wkc_inc, bus_if.bus_rd,
         bus_if.bus_wr, bus_if.bus_address, bus_if.bus_wdata} !== 39'h0) begin
      fails++;
      $display("FAIL reset_outputs: got rdy=%b out=%h v=%b done=%b wkc=%0d rd=%b wr=%b a=%h wd=%h, expected all zero",
               byte_ready, byte_out, byte_out_valid, dg_done, wkc_inc, bus_if.bus_rd,
               bus_if.bus_wr, bus_if.bus_address, bus_if.bus_wdata);
    end
    rst = 1'b0;
  endtask

  task automatic test_read();
    op_t e, o;
    logic [8:0] ob;
    logic [7:0] eb;
    clear_cfg();
    set_ch(0, 1'b1, 1'b0, 32'h14141413, 16'd4, 16'h3333);
    mem[16'h3334] = 8'hA1; mem[16'h3335] = 8'hA2;
    stim_bytes = '{8'h55, 8'h66};
    exp_ops.push_back('{1'b0, 1'b0, 16'h3334, 8'h00});
    exp_ops.push_back('{1'b0, 1'b0, 16'h3335, 8'h00});
    exp_out.push_back(8'hA1); exp_out.push_back(8'hA2);
    exp_wkc.push_back(2'd1);
    run_dg(CMD_LRD, 32'h14141414, 16'd2, 0);
    while (exp_ops.size() > 0) begin
      e = exp_ops.pop_front();
      o = (obs_ops.size() > 0) ? obs_ops.pop_front() : '{1'b1, 1'b0, 16'h0, 8'h0};
      tests++;
      if (o !== e) begin fails++; $display("FAIL read_busop: got %h, expected %h", o, e); end
    end
    while (exp_out.size() > 0) begin
      eb = exp_out.pop_front();
      ob = (obs_out.size() > 0) ? {1'b0, obs_out.pop_front()} : 9'h100;
      tests++;
      if (ob !== {1'b0, eb}) begin fails++; $display("FAIL read_byte: got %h, expected %h", ob, eb); end
    end
    eb = {6'd0, exp_wkc.pop_front()};
    tests++;
    if (!done_seen || obs_wkc.size() != 1 || {6'd0, obs_wkc[0]} !== eb) begin
      fails++; $display("FAIL read_wkc: done=%0d got %0d, expected %0d", done_seen, wkc_inc, eb);
    end
    tests++;
    if (first_strobe != first_acc + 1 || first_valid != first_acc + 2) begin
      fails++; $display("FAIL read_latency: acc=%0d rd=%0d valid=%0d, expected rd=acc+1 valid=acc+2",
                        first_acc, first_strobe, first_valid);
    end
    tests++;
    if (done_cyc != last_valid + 1 || obs_ops.size() != 0 || obs_out.size() != 0) begin
      fails++; $display("FAIL read_done_timing: done=%0d last_valid=%0d extra_ops=%0d extra_bytes=%0d, expected done=last+1 no extras",
                        done_cyc, last_valid, obs_ops.size(), obs_out.size());
    end
  endtask

  task automatic test_write();
    op_t e, o;
    logic [8:0] ob;
    logic [7:0] eb;
    clear_cfg();
    set_ch(0, 1'b0, 1'b1, 32'h14141413, 16'd4, 16'h3333);
    stim_bytes = '{8'h11, 8'h22, 8'h33};
    exp_ops.push_back('{1'b0, 1'b1, 16'h3333, 8'h22});
    exp_ops.push_back('{1'b0, 1'b1, 16'h3334, 8'h33});
    exp_out.push_back(8'h11); exp_out.push_back(8'h22); exp_out.push_back(8'h33);
    exp_wkc.push_back(2'd2);
    run_dg(CMD_LWR, 32'h14141412, 16'd3, 1);
    while (exp_ops.size() > 0) begin
      e = exp_ops.pop_front();
      o = (obs_ops.size() > 0) ? obs_ops.pop_front() : '{1'b1, 1'b0, 16'h0, 8'h0};
      tests++;
      if (o !== e) begin fails++; $display("FAIL write_busop: got %h, expected %h", o, e); end
    end
    while (exp_out.size() > 0) begin
      eb = exp_out.pop_front();
      ob = (obs_out.size() > 0) ? {1'b0, obs_out.pop_front()} : 9'h100;
      tests++;
      if (ob !== {1'b0, eb}) begin fails++; $display("FAIL write_byte: got %h, expected %h", ob, eb); end
    end
    eb = {6'd0, exp_wkc.pop_front()};
    tests++;
    if (!done_seen || obs_wkc.size() != 1 || {6'd0, obs_wkc[0]} !== eb) begin
      fails++; $display("FAIL write_wkc: done=%0d got %0d, expected %0d", done_seen, wkc_inc, eb);
    end
    tests++;
    if (obs_ops.size() != 0 || both_cnt != 0) begin
      fails++; $display("FAIL write_extra: extra_ops=%0d both_strobes=%0d, expected 0 and 0", obs_ops.size(), both_cnt);
    end
  endtask

  task automatic test_overlap_lrw();
    op_t e, o;
    logic [8:0] ob;
    logic [7:0] eb;
    clear_cfg();
    set_ch(0, 1'b1, 1'b1, 32'h00001000, 16'd4, 16'h0100);
    set_ch(1, 1'b1, 1'b1, 32'h00001000, 16'd4, 16'h0800);
    mem[16'h0100] = 8'h77;
    stim_bytes = '{8'h5A};
    exp_ops.push_back('{1'b0, 1'b0, 16'h0100, 8'h00});
    exp_ops.push_back('{1'b0, 1'b1, 16'h0100, 8'h5A});
    exp_out.push_back(8'h77);
    exp_wkc.push_back(2'd3);
    run_dg(CMD_LRW, 32'h00001000, 16'd1, 0);
    while (exp_ops.size() > 0) begin
      e = exp_ops.pop_front();
      o = (obs_ops.size() > 0) ? obs_ops.pop_front() : '{1'b1, 1'b0, 16'h0, 8'h0};
      tests++;
      if (o !== e) begin fails++; $display("FAIL lrw_busop: got %h, expected %h", o, e); end
    end
    while (exp_out.size() > 0) begin
      eb = exp_out.pop_front();
      ob = (obs_out.size() > 0) ? {1'b0, obs_out.pop_front()} : 9'h100;
      tests++;
      if (ob !== {1'b0, eb}) begin fails++; $display("FAIL lrw_byte: got %h, expected %h", ob, eb); end
    end
    eb = {6'd0, exp_wkc.pop_front()};
    tests++;
    if (!done_seen || obs_wkc.size() != 1 || {6'd0, obs_wkc[0]} !== eb) begin
      fails++; $display("FAIL lrw_wkc: done=%0d got %0d, expected %0d", done_seen, wkc_inc, eb);
    end
    tests++;
    if (obs_ops.size() != 0 || both_cnt != 0) begin
      fails++; $display("FAIL lrw_extra: extra_ops=%0d both_strobes=%0d, expected 0 and 0", obs_ops.size(), both_cnt);
    end
  endtask

  task automatic test_wrap();
    op_t e, o;
    logic [8:0] ob;
    logic [7:0] eb;
    clear_cfg();
    set_ch(2, 1'b1, 1'b0, 32'hFFFFFFFE, 16'd4, 16'h0200);
    mem[16'h0201] = 8'hC1; mem[16'h0202] = 8'hC2;
    stim_bytes = '{8'h00, 8'h00};
    exp_ops.push_back('{1'b0, 1'b0, 16'h0201, 8'h00});
    exp_ops.push_back('{1'b0, 1'b0, 16'h0202, 8'h00});
    exp_out.push_back(8'hC1); exp_out.push_back(8'hC2);
    exp_wkc.push_back(2'd1);
    run_dg(CMD_LRD, 32'hFFFFFFFF, 16'd2, 2);
    while (exp_ops.size() > 0) begin
      e = exp_ops.pop_front();
      o = (obs_ops.size() > 0) ? obs_ops.pop_front() : '{1'b1, 1'b0, 16'h0, 8'h0};
      tests++;
      if (o !== e) begin fails++; $display("FAIL wrap_busop: got %h, expected %h", o, e); end
    end
    while (exp_out.size() > 0) begin
      eb = exp_out.pop_front();
      ob = (obs_out.size() > 0) ? {1'b0, obs_out.pop_front()} : 9'h100;
      tests++;
      if (ob !== {1'b0, eb}) begin fails++; $display("FAIL wrap_byte: got %h, expected %h", ob, eb); end
    end
    eb = {6'd0, exp_wkc.pop_front()};
    tests++;
    if (!done_seen || obs_wkc.size() != 1 || {6'd0, obs_wkc[0]} !== eb) begin
      fails++; $display("FAIL wrap_wkc: done=%0d got %0d, expected %0d", done_seen, wkc_inc, eb);
    end
  endtask

  task automatic test_passthrough();
    logic [8:0] ob;
    logic [7:0] eb;
    clear_cfg();
    set_ch(0, 1'b1, 1'b1, 32'h14141400, 16'h0100, 16'h4000);
    stim_bytes = '{8'hDE, 8'hAD};
    exp_out.push_back(8'hDE); exp_out.push_back(8'hAD);
    exp_wkc.push_back(2'd0);
    run_dg(8'h00, 32'h14141414, 16'd2, 0);
    while (exp_out.size() > 0) begin
      eb = exp_out.pop_front();
      ob = (obs_out.size() > 0) ? {1'b0, obs_out.pop_front()} : 9'h100;
      tests++;
      if (ob !== {1'b0, eb}) begin fails++; $display("FAIL pass_byte: got %h, expected %h", ob, eb); end
    end
    eb = {6'd0, exp_wkc.pop_front()};
    tests++;
    if (!done_seen || obs_wkc.size() != 1 || {6'd0, obs_wkc[0]} !== eb) begin
      fails++; $display("FAIL pass_wkc: done=%0d got %0d, expected %0d", done_seen, wkc_inc, eb);
    end
    tests++;
    if (obs_ops.size() != 0 || first_strobe != -1) begin
      fails++; $display("FAIL pass_no_bus: got %0d ops, expected 0", obs_ops.size());
    end
    tests++;
    if (first_valid != first_acc + 1) begin
      fails++; $display("FAIL pass_latency: got valid at %0d, expected %0d", first_valid, first_acc + 1);
    end
  endtask

  task automatic test_zero_len();
    clear_cfg();
    set_ch(0, 1'b1, 1'b1, 32'h14141400, 16'h0100, 16'h4000);
    stim_bytes = '{8'hEE};
    exp_wkc.push_back(2'd0);
    run_dg(CMD_LRD, 32'h14141414, 16'd0, 0);
    tests++;
    if (!done_seen || done_cyc != 2) begin
      fails++; $display("FAIL zero_len_done: got done at cycle %0d, expected 2", done_cyc);
    end
    tests++;
    if (obs_wkc.size() != 1 || obs_wkc[0] !== exp_wkc.pop_front() || obs_out.size() != 0 || obs_ops.size() != 0) begin
      fails++; $display("FAIL zero_len_quiet: got wkc=%0d bytes=%0d ops=%0d, expected 0 0 0",
                        wkc_inc, obs_out.size(), obs_ops.size());
    end
  endtask

  task automatic test_stall_reset();
    bit sent, seen;
    logic rdy;
    int dones;
    clear_cfg();
    set_ch(0, 1'b1, 1'b0, 32'h14141413, 16'd4, 16'h3333);
    bus_if.bus_ack = 1'b0;
    @(negedge rxc);
    dg_cmd = CMD_LRD; dg_addr = 32'h14141414; dg_len = 16'd2; dg_start = 1'b1;
    sent = 0; seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge rxc);
      rdy = byte_ready;
      if (bus_if.bus_rd) begin
        seen = 1;
      end else begin
        dg_start = 1'b0;
        byte_valid = 1'b0;
        if (rdy && !sent) begin byte_valid = 1'b1; byte_in = 8'h99; sent = 1; end
      end
    end
    byte_valid = 1'b0;
    tests++;
    if (!seen) begin fails++; $display("FAIL stall_rd_start: got bus_rd=0 after 20 cycles, expected 1"); end
    for (int k = 0; k < 5; k++) begin
      @(negedge rxc);
      tests++;
      if ({bus_if.bus_rd, byte_ready} !== 2'b10) begin
        fails++; $display("FAIL stall_hold: got rd=%b ready=%b, expected rd=1 ready=0", bus_if.bus_rd, byte_ready);
      end
    end
    rst = 1'b1;
    @(negedge rxc);
    tests++;
    if ({byte_ready, byte_out, byte_out_valid, dg_done, wkc_inc, bus_if.bus_rd,
         bus_if.bus_wr, bus_if.bus_address, bus_if.bus_wdata} !== 39'h0) begin
      fails++;
      $display("FAIL stall_reset_outputs: got rdy=%b out=%h v=%b done=%b rd=%b wr=%b a=%h wd=%h, expected all zero",
               byte_ready, byte_out, byte_out_valid, dg_done, bus_if.bus_rd,
               bus_if.bus_wr, bus_if.bus_address, bus_if.bus_wdata);
    end
    rst = 1'b0;
    dones = 0;
    repeat (10) begin
      @(negedge rxc);
      if (dg_done || byte_out_valid || bus_if.bus_rd) dones++;
    end
    tests++;
    if (dones != 0) begin fails++; $display("FAIL stall_no_done: got %0d active cycles, expected 0", dones); end
  endtask

  initial begin
    clear_cfg();
    bus_if.bus_ack = 1'b0;
    bus_if.bus_rdata = '0;
    test_reset();
    test_read();
    test_write();
    test_overlap_lrw();
    test_wrap();
    test_passthrough();
    test_zero_len();
    test_stall_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
